// File: rtl/qam_map_sched.sv
// qam_map_sched: groups a serial coded-bit stream into carrier words
// for the OFDM subcarrier mapper, with SIGNAL/DATA sequencing and padding.
module qam_map_sched #(
  parameter int N_SD     = 48,
  parameter int SIG_SYMS = 1,
  parameter int CW       = 6
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          DAT_I,
  input  logic          CYC_I,
  input  logic          STB_I,
  input  logic          WE_I,
  output logic          ACK_O,
  input  logic [1:0]    MODE_I,
  output logic [CW-1:0] DAT_O,
  output logic [1:0]    MOD_O,
  output logic          SYM_LAST_O,
  output logic          CYC_O,
  output logic          STB_O,
  output logic          WE_O,
  input  logic          ACK_I
);

  localparam int CCW = $clog2(N_SD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SIG,
    S_DATA,
    S_PAD,
    S_FLUSH
  } state_t;

  state_t          r_st;
  state_t          w_nxt;
  logic [1:0]      r_mode;
  logic [2:0]      r_bit;
  logic [CCW-1:0]  r_car;
  logic [15:0]     r_sym;
  logic [CW-1:0]   r_acc;
  logic [CW-1:0]   r_dat;
  logic [1:0]      r_mod;
  logic            r_last;
  logic            r_cyc;
  logic            r_stb;

  logic            w_ena;
  logic            w_halt;
  logic            w_live;
  logic            w_pad_step;
  logic            w_shift;
  logic            w_bit;
  logic [1:0]      w_mode;
  logic [2:0]      w_bpsc;
  logic            w_done;
  logic            w_car_last;
  logic            w_sym_done;
  logic            w_sig_end;
  logic            w_empty;
  logic            w_flush_ok;
  logic [CW-1:0]   w_word;

  assign w_ena      = CYC_I & STB_I & WE_I;
  assign w_halt     = r_stb & ~ACK_I;
  assign w_live     = (r_st == S_SIG) | (r_st == S_DATA);
  assign ACK_O      = w_ena & ~w_halt & w_live;
  assign w_pad_step = (r_st == S_PAD) & ~w_halt;
  assign w_shift    = ACK_O | w_pad_step;
  assign w_bit      = (r_st == S_PAD) ? 1'b0 : DAT_I;

  // SIGNAL symbols are always BPSK, whatever mode the frame carries
  assign w_mode = (r_sym < 16'(SIG_SYMS)) ? 2'b00 : r_mode;

  always_comb begin
    w_bpsc = 3'd1;
    unique case (w_mode)
      2'b00: w_bpsc = 3'd1;
      2'b01: w_bpsc = 3'd2;
      2'b10: w_bpsc = 3'd4;
      2'b11: w_bpsc = 3'd6;
      default: w_bpsc = 3'd1;
    endcase
  end

  assign w_word     = r_acc | (CW'(w_bit) << r_bit);
  assign w_done     = w_shift & (r_bit == (w_bpsc - 3'd1));
  assign w_car_last = (r_car == CCW'(N_SD - 1));
  assign w_sym_done = w_done & w_car_last;
  assign w_sig_end  = w_sym_done &
                      (r_sym == 16'(SIG_SYMS - 1));
  assign w_empty    = (r_bit == 3'd0) & (r_car == '0);
  assign w_flush_ok = ~r_stb | ACK_I;

  always_ff @(posedge CLK_I) begin
    if (RST_I) r_st <= S_IDLE;
    else       r_st <= w_nxt;
  end

  always_comb begin
    w_nxt = r_st;
    unique case (r_st)
      S_IDLE: begin
        if (CYC_I) begin
          if (SIG_SYMS > 0) w_nxt = S_SIG;
          else              w_nxt = S_DATA;
        end
      end
      S_SIG, S_DATA: begin
        if (!CYC_I) begin
          if (!w_empty)        w_nxt = S_PAD;
          else if (w_flush_ok) w_nxt = S_IDLE;
          else                 w_nxt = S_FLUSH;
        end else if (r_st == S_SIG && w_sig_end) begin
          w_nxt = S_DATA;
        end
      end
      S_PAD: begin
        if (w_sym_done) w_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (w_flush_ok) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_mode <= '0;
      r_bit  <= '0;
      r_car  <= '0;
      r_sym  <= '0;
      r_acc  <= '0;
      r_dat  <= '0;
      r_mod  <= '0;
      r_last <= 1'b0;
      r_cyc  <= 1'b0;
      r_stb  <= 1'b0;
    end else begin
      if (r_st == S_IDLE) begin
        r_bit <= '0;
        r_car <= '0;
        r_sym <= '0;
        r_acc <= '0;
        if (CYC_I) begin
          r_mode <= MODE_I;
          r_cyc  <= 1'b1;
        end
      end else if (w_nxt == S_IDLE) begin
        r_cyc <= 1'b0;
      end

      if (w_done) begin
        r_dat  <= w_word;
        r_mod  <= w_mode;
        r_last <= w_car_last;
        r_stb  <= 1'b1;
        r_bit  <= '0;
        r_acc  <= '0;
        r_car  <= w_car_last ? '0 : r_car + 1'b1;
        if (w_car_last && r_sym != 16'hFFFF)
          r_sym <= r_sym + 16'd1;
      end else begin
        if (w_shift) begin
          r_acc <= w_word;
          r_bit <= r_bit + 3'd1;
        end
        if (ACK_I) r_stb <= 1'b0;
      end
    end
  end

  assign DAT_O      = r_dat;
  assign MOD_O      = r_mod;
  assign SYM_LAST_O = r_last;
  assign CYC_O      = r_cyc;
  assign STB_O      = r_stb;
  assign WE_O       = r_stb;

endmodule
